calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
//   Front-end controller for the 4-bit calculator ALU. It takes key events
//   (digits, operator, equals, clear-key) and builds operand A and operand B.
//   It drives num1/num2/op_selected into the registered ALU, then captures the
//   ALU result one cycle after the ALU samples it.
//   It also supports chained and repeated calculations and raises carry/borrow
//   and entry-error flags for the display layer.
// PARAMETERS
//   W      4   operand/result width; must equal the ALU width (4)
//   RADIX  10  base for multi-digit entry (operand = operand*RADIX + digit)
// PORTS
//   clk           in   1  system clock, rising edge
//   clear         in   1  asynchronous active-high reset
//   digit_valid   in   1  one-cycle strobe: digit key pressed
//   digit         in   4  digit value, qualified by digit_valid
//   op_valid      in   1  one-cycle strobe: operator key pressed
//   op_sub        in   1  operator with op_valid: 0 add, 1 subtract
//   eq_valid      in   1  one-cycle strobe: equals key
//   clr_key       in   1  one-cycle strobe: user clear (synchronous)
//   alu_result    in   W  ALU number_out
//   num1          out  W  operand A to ALU (registered)
//   num2          out  W  operand B to ALU (registered)
//   op_selected   out  1  operation to ALU (registered)
//   display_val   out  W  value to show
//   result_valid  out  1  one-cycle pulse: display_val holds a new result
//   ovf           out  1  carry (add) / borrow (sub) of the last result
//   key_err       out  1  one-cycle pulse: digit rejected
//   busy          out  1  high in S_EXEC and S_WAIT
// BEHAVIOUR
// - clear: state S_A; A, B, op, display_val, ovf, and all pulses are 0.
// - Key priority when several keys fire in one cycle: clr_key > eq > op > digit.
//   Only the highest-priority key acts.
// - clr_key in any state, including S_EXEC and S_WAIT:
//   - same as reset, but synchronous.
//   - any in-flight result is discarded and result_valid does not pulse.
// - Digit entry: new = cur*RADIX + digit.
//   - Rejected if digit >= RADIX or new > 2^W-1.
//   - On rejection the operand is unchanged and key_err pulses for 1 cycle.
// - S_A: digit updates A; op latches op and sets B = 0, go to S_B; eq ignored.
//   display_val = A.
// - S_B: digit updates B; op replaces the operator; eq goes to S_EXEC.
//   display_val = B.
// - S_EXEC: one cycle; the ALU samples num1/num2/op_selected at its end.
//   Go to S_WAIT. All keys except clr_key are ignored and dropped.
// - S_WAIT: one cycle; at its end the controller:
//   - captures alu_result into display_val and A;
//   - sets ovf (add: A+B > 2^W-1; sub: A < B, from the pre-capture A and B);
//   - pulses result_valid;
//   - goes to S_SHOW. Keys are dropped as in S_EXEC.
// - S_SHOW: display_val holds the result.
//   - digit: A = digit (new calculation, same reject rules), go to S_A.
//   - op: chain; A = result, latch op, B = 0, go to S_B.
//   - eq: repeat the last op with the same B on A = result, go to S_EXEC.
// - Latency: eq sampled at edge t -> ALU samples at t+1 -> display_val,
//   ovf, and result_valid update at edge t+2.
// - num1 = A, num2 = B, and op_selected = op are registered.
//   They stay constant through S_EXEC and S_WAIT.
// - Arithmetic wraps modulo 2^W. ovf is sticky until the next result, clear,
//   or clr_key.
// - key_err and result_valid are never asserted for more than 1 cycle per key.
// TESTING
// 1. Assert clear mid-calculation (in S_WAIT) -> all outputs are 0
//    immediately, busy=0, and no result_valid follows.
// 2. Keys 3,+,4,= -> num1=3, num2=4, op_selected=0.
//    result_valid comes 2 cycles after eq; display_val=7, ovf=0.
// 3. Keys 9,+,9,= -> display_val=2 (18 mod 16), ovf=1.
//    Then +,1,= -> display_val=3, ovf=0.
// 4. Keys 2,-,5,= -> display_val=13, ovf=1.
//    Then = again -> 13-5 = 8, ovf=0.
// 5. Keys 1,6 -> key_err pulses, A stays 1. Keys 1,5 -> A=15.
//    Digit 10 -> key_err pulses.
// 6. eq_valid and digit_valid together in S_B -> eq wins, digit dropped.
//    clr_key in S_EXEC -> S_A, display_val=0, no result_valid.

Source files
------------

// File: rtl/calc_sequencer.sv
// Key-entry front end for the 4-bit calculator: builds operands A/B from key strobes,
// drives the registered ALU and captures its result two edges after equals.
module calc_sequencer #(
    parameter int W     = 4,
    parameter int RADIX = 10
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         digit_valid,
    input  logic [3:0]   digit,
    input  logic         op_valid,
    input  logic         op_sub,
    input  logic         eq_valid,
    input  logic         clr_key,
    input  logic [W-1:0] alu_result,
    output logic [W-1:0] num1,
    output logic [W-1:0] num2,
    output logic         op_selected,
    output logic [W-1:0] display_val,
    output logic         result_valid,
    output logic         ovf,
    output logic         key_err,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_EXEC,
        S_WAIT,
        S_SHOW
    } state_t;

    // Entry arithmetic is done wide enough that cur*RADIX+digit never wraps before the range test.
    localparam int             EW      = W + 8;
    localparam logic [EW-1:0]  MAX_VAL = {{(EW-W){1'b0}}, {W{1'b1}}};
    localparam logic [EW-1:0]  RADIX_E = EW'(RADIX);

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_op;
    logic [W-1:0]   r_disp;
    logic           r_ovf;
    logic           r_result_valid;
    logic           r_key_err;
    logic           r_busy;

    logic           w_key_clr;
    logic           w_key_eq;
    logic           w_key_op;
    logic           w_key_dig;
    logic [W-1:0]   w_cur;
    logic [EW-1:0]  w_entry;
    logic           w_digit_ok;
    logic [W:0]     w_sum;
    logic           w_carry;
    logic           w_borrow;

    // Only the highest-priority key acts: clr_key > eq > op > digit.
    assign w_key_clr = clr_key;
    assign w_key_eq  = eq_valid & ~clr_key;
    assign w_key_op  = op_valid & ~clr_key & ~eq_valid;
    assign w_key_dig = digit_valid & ~clr_key & ~eq_valid & ~op_valid;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_cur = '0;
        case (r_state)
            S_A:     w_cur = r_a;
            S_B:     w_cur = r_b;
            default: w_cur = '0;
        endcase
    end

    assign w_entry    = EW'(w_cur) * RADIX_E + EW'(digit);
    assign w_digit_ok = (EW'(digit) < RADIX_E) && (w_entry <= MAX_VAL);

    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_carry  = w_sum[W];
    assign w_borrow = (r_a < r_b);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state        <= S_A;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= 1'b0;
            r_disp         <= '0;
            r_ovf          <= 1'b0;
            r_result_valid <= 1'b0;
            r_key_err      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_key_err      <= 1'b0;

            if (w_key_clr) begin
                // Synchronous user clear also discards any in-flight result.
                r_state <= S_A;
                r_a     <= '0;
                r_b     <= '0;
                r_op    <= 1'b0;
                r_disp  <= '0;
                r_ovf   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_A: begin
                        if (w_key_op) begin
                            r_op    <= op_sub;
                            r_b     <= '0;
                            r_disp  <= '0;
                            r_state <= S_B;
                        end else if (w_key_dig) begin
                            if (w_digit_ok) begin
                                r_a    <= w_entry[W-1:0];
                                r_disp <= w_entry[W-1:0];
                            end else begin
                                r_key_err <= 1'b1;
                            end
                        end
                    end

                    S_B: begin
                        if (w_key_eq) begin
                            r_state <= S_EXEC;
                            r_busy  <= 1'b1;
                        end else if (w_key_op) begin
                            r_op <= op_sub;
                        end else if (w_key_dig) begin
                            if (w_digit_ok) begin
                                r_b    <= w_entry[W-1:0];
                                r_disp <= w_entry[W-1:0];
                            end else begin
                                r_key_err <= 1'b1;
                            end
                        end
                    end

                    S_EXEC: begin
                        r_state <= S_WAIT;
                    end

                    S_WAIT: begin
                        r_a            <= alu_result;
                        r_disp         <= alu_result;
                        r_ovf          <= r_op ? w_borrow : w_carry;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_SHOW;
                    end

                    S_SHOW: begin
                        if (w_key_eq) begin
                            // Repeat: same op and B applied to the result already held in A.
                            r_state <= S_EXEC;
                            r_busy  <= 1'b1;
                        end else if (w_key_op) begin
                            r_op    <= op_sub;
                            r_b     <= '0;
                            r_disp  <= '0;
                            r_state <= S_B;
                        end else if (w_key_dig) begin
                            if (w_digit_ok) begin
                                r_a     <= w_entry[W-1:0];
                                r_disp  <= w_entry[W-1:0];
                                r_state <= S_A;
                            end else begin
                                r_key_err <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_A;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign num1         = r_a;
    assign num2         = r_b;
    assign op_selected  = r_op;
    assign display_val  = r_disp;
    assign result_valid = r_result_valid;
    assign ovf          = r_ovf;
    assign key_err      = r_key_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural registered 4-bit ALU attached.
module tb_calc_sequencer;

    logic       clk;
    logic       clear;
    logic       digit_valid;
    logic [3:0] digit;
    logic       op_valid;
    logic       op_sub;
    logic       eq_valid;
    logic       clr_key;
    logic [3:0] alu_result;
    logic [3:0] num1;
    logic [3:0] num2;
    logic       op_selected;
    logic [3:0] display_val;
    logic       result_valid;
    logic       ovf;
    logic       key_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    calc_sequencer #(.W(4), .RADIX(10)) dut (
        .clk          (clk),
        .clear        (clear),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .op_valid     (op_valid),
        .op_sub       (op_sub),
        .eq_valid     (eq_valid),
        .clr_key      (clr_key),
        .alu_result   (alu_result),
        .num1         (num1),
        .num2         (num2),
        .op_selected  (op_selected),
        .display_val  (display_val),
        .result_valid (result_valid),
        .ovf          (ovf),
        .key_err      (key_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: samples operands every edge, wraps modulo 16.
    always @(posedge clk) begin
        alu_result <= op_selected ? (num1 - num2) : (num1 + num2);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step();
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic key_op(input logic s);
        op_valid = 1'b1;
        op_sub   = s;
        step();
        op_valid = 1'b0;
        op_sub   = 1'b0;
    endtask

    task automatic key_eq();
        eq_valid = 1'b1;
        step();
        eq_valid = 1'b0;
    endtask

    task automatic key_clr();
        clr_key = 1'b1;
        step();
        clr_key = 1'b0;
    endtask

    // Called just after the edge that sampled eq; result must land exactly two edges later.
    task automatic expect_result(input string tag, input logic [3:0] val, input logic o);
        check({tag, "_busy_exec"}, busy, 1);
        check({tag, "_rv_early"}, result_valid, 0);
        step();
        check({tag, "_rv_wait"}, result_valid, 0);
        step();
        check({tag, "_rv"}, result_valid, 1);
        check({tag, "_disp"}, display_val, val);
        check({tag, "_ovf"}, ovf, o);
        check({tag, "_busy_done"}, busy, 0);
        step();
        check({tag, "_rv_pulse"}, result_valid, 0);
    endtask

    initial begin
        clear       = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'd0;
        op_valid    = 1'b0;
        op_sub      = 1'b0;
        eq_valid    = 1'b0;
        clr_key     = 1'b0;
        #12;
        check("rst_num1", num1, 0);
        check("rst_num2", num2, 0);
        check("rst_op", op_selected, 0);
        check("rst_disp", display_val, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_kerr", key_err, 0);
        clear = 1'b0;
        step();

        // Async clear while waiting for the ALU.
        key_digit(4'd3);
        key_op(1'b0);
        key_digit(4'd4);
        key_eq();
        step();
        check("t1_busy_wait", busy, 1);
        #2 clear = 1'b1;
        #1;
        check("t1_num1", num1, 0);
        check("t1_num2", num2, 0);
        check("t1_disp", display_val, 0);
        check("t1_busy", busy, 0);
        #1 clear = 1'b0;
        step();
        check("t1_no_rv0", result_valid, 0);
        step();
        check("t1_no_rv1", result_valid, 0);
        check("t1_disp_after", display_val, 0);

        // 3 + 4 = 7
        key_digit(4'd3);
        check("t2_disp_a", display_val, 3);
        key_op(1'b0);
        key_digit(4'd4);
        check("t2_disp_b", display_val, 4);
        key_eq();
        check("t2_num1", num1, 3);
        check("t2_num2", num2, 4);
        check("t2_op", op_selected, 0);
        expect_result("t2", 4'd7, 1'b0);

        // New calculation from the result screen: 9 + 9 wraps to 2 with carry.
        key_digit(4'd9);
        check("t3_num1", num1, 9);
        key_op(1'b0);
        key_digit(4'd9);
        key_eq();
        expect_result("t3", 4'd2, 1'b1);
        // Chain: 2 + 1 = 3
        key_op(1'b0);
        check("t3_chain_num1", num1, 2);
        check("t3_chain_num2", num2, 0);
        key_digit(4'd1);
        key_eq();
        expect_result("t3c", 4'd3, 1'b0);

        // 2 - 5 wraps to 13 with borrow, then repeat: 13 - 5 = 8.
        key_clr();
        key_digit(4'd2);
        key_op(1'b1);
        key_digit(4'd5);
        key_eq();
        check("t4_op", op_selected, 1);
        expect_result("t4", 4'd13, 1'b1);
        key_eq();
        check("t4r_num1", num1, 13);
        check("t4r_num2", num2, 5);
        expect_result("t4r", 4'd8, 1'b0);

        // Entry range limits.
        key_clr();
        key_digit(4'd1);
        check("t5_kerr_idle", key_err, 0);
        key_digit(4'd6);
        check("t5_kerr_16", key_err, 1);
        check("t5_a_kept", num1, 1);
        step();
        check("t5_kerr_pulse", key_err, 0);
        key_clr();
        key_digit(4'd1);
        key_digit(4'd5);
        check("t5_a15", num1, 15);
        check("t5_kerr_15", key_err, 0);
        key_clr();
        key_digit(4'd10);
        check("t5_kerr_d10", key_err, 1);
        check("t5_a_d10", num1, 0);

        // eq beats digit in the same cycle.
        key_clr();
        key_digit(4'd3);
        key_op(1'b0);
        key_digit(4'd4);
        eq_valid    = 1'b1;
        digit_valid = 1'b1;
        digit       = 4'd7;
        step();
        eq_valid    = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        check("t6_num2_kept", num2, 4);
        expect_result("t6", 4'd7, 1'b0);

        // clr_key during S_EXEC discards the calculation.
        key_clr();
        key_digit(4'd5);
        key_op(1'b0);
        key_digit(4'd2);
        key_eq();
        check("t6c_busy", busy, 1);
        key_clr();
        check("t6c_busy_clr", busy, 0);
        check("t6c_disp", display_val, 0);
        check("t6c_num1", num1, 0);
        check("t6c_rv0", result_valid, 0);
        step();
        check("t6c_rv1", result_valid, 0);
        step();
        check("t6c_rv2", result_valid, 0);
        // Still in S_A: a digit loads A directly.
        key_digit(4'd6);
        check("t6c_state_a", num1, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
